// File: rtl/value_refill.sv
// Bitstream refill for an arithmetic decoder: keeps a VALUE_W-bit window and merges bytes on demand.
// Optional bypass lookahead lanes are enabled by defining VALUE_REFILL_LOOKAHEAD_EN.
module value_refill #(
    parameter int VALUE_W    = 17,
    parameter int MAX_SHIFT  = 7,
    parameter int EP_LANES   = 4,
    parameter int INIT_BYTES = 2,
    parameter int SHIFT_W    = $clog2(MAX_SHIFT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    input  logic                          shift_valid,
    input  logic [SHIFT_W-1:0]            shift_amt,
    output logic                          shift_ready,
    output logic [VALUE_W-1:0]            value,
    output logic [3:0]                    bits_needed,
    output logic                          value_valid,
    output logic [EP_LANES*VALUE_W-1:0]   ep_value,
    output logic [EP_LANES-1:0]           ep_ok
);

    localparam int CNT_W = $clog2(INIT_BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_STALL} state_t;

    state_t              state_q, state_d;
    logic [VALUE_W-1:0]  value_q, value_d;
    logic signed [3:0]   bits_q, bits_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    int                  n_int;
    logic [VALUE_W-1:0]  byte_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            value_q <= '0;
            bits_q  <= -4'sd8;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        bits_d      = bits_q;
        cnt_d       = cnt_q;
        shift_ready = 1'b0;
        byte_ready  = 1'b0;
        n_int       = int'(bits_q) + int'(shift_amt);
        byte_sh     = VALUE_W'({{VALUE_W{1'b0}}, byte_data} << n_int[2:0]);

        if (start) begin
            state_d = S_INIT;
            value_d = '0;
            bits_d  = -4'sd8;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        value_d = VALUE_W'({value_q, byte_data});
                        cnt_d   = cnt_q + 1'b1;
                        if (int'(cnt_q) + 1 == INIT_BYTES)
                            state_d = S_RUN;
                    end
                end
                S_RUN, S_STALL: begin
                    if (shift_valid) begin
                        if (n_int < 0) begin
                            shift_ready = 1'b1;
                            value_d     = value_q << shift_amt;
                            bits_d      = 4'(n_int);
                            state_d     = S_RUN;
                        end else if (byte_valid) begin
                            // Shift and byte merge complete in the same cycle.
                            shift_ready = 1'b1;
                            byte_ready  = 1'b1;
                            value_d     = (value_q << shift_amt) + byte_sh;
                            bits_d      = 4'(n_int - 8);
                            state_d     = S_RUN;
                        end else begin
                            state_d = S_STALL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign value       = value_q;
    assign bits_needed = bits_q;
    assign value_valid = (state_q == S_RUN);

`ifdef VALUE_REFILL_LOOKAHEAD_EN
    for (genvar k = 0; k < EP_LANES; k++) begin : g_lane
        logic signed [5:0]  pos;
        logic [VALUE_W-1:0] lane_byte;

        assign pos       = 6'(bits_q) + 6'(k + 1);
        assign lane_byte = VALUE_W'({{VALUE_W{1'b0}}, byte_data} << pos[3:0]);
        assign ep_value[k*VALUE_W +: VALUE_W] =
            VALUE_W'(value_q << (k + 1)) + ((pos >= 0) ? lane_byte : '0);
        // A lane that would need a second byte is never valid.
        assign ep_ok[k] = value_valid & ((pos < 0) | byte_valid) & (pos < 6'sd8);
    end
`else
    assign ep_value = '0;
    assign ep_ok    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && shift_valid && (state_q == S_RUN || state_q == S_STALL))
            assert (int'(shift_amt) <= MAX_SHIFT);
    end

endmodule

// File: tb/tb_value_refill.sv
// Directed bench for value_refill: init, shifts, merge, stall, lookahead and reset/start priority.
module tb_value_refill;

    localparam int VW = 17;
    localparam int SW = 3;
    localparam int EL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              shift_valid;
    logic [SW-1:0]     shift_amt;
    logic              shift_ready;
    logic [VW-1:0]     value;
    logic [3:0]        bits_needed;
    logic              value_valid;
    logic [EL*VW-1:0]  ep_value;
    logic [EL-1:0]     ep_ok;

    int n_checks = 0;
    int n_errors = 0;

    value_refill #(.VALUE_W(VW), .MAX_SHIFT(7), .EP_LANES(EL), .INIT_BYTES(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .shift_valid(shift_valid), .shift_amt(shift_amt), .shift_ready(shift_ready),
        .value(value), .bits_needed(bits_needed), .value_valid(value_valid),
        .ep_value(ep_value), .ep_ok(ep_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start       = 1'b0;
        byte_valid  = 1'b0;
        shift_valid = 1'b0;
        byte_data   = 8'h00;
        shift_amt   = '0;
    endtask

    task automatic do_init(input logic [7:0] b0, input logic [7:0] b1);
        idle_in();
        start = 1'b1;
        step();
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b0;
        #1 check("init_br0", byte_ready, 1'b1);
        step();
        byte_data = b1;
        #1 check("init_br1", byte_ready, 1'b1);
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        rst         = 1'b1;
        shift_valid = 1'b1;
        byte_valid  = 1'b1;
        byte_data   = 8'h55;
        step();
        step();
        check("rst_value", value, 17'h0);
        check("rst_bits", bits_needed, 4'h8);
        check("rst_vv", value_valid, 1'b0);
        check("rst_sr", shift_ready, 1'b0);
        check("rst_br", byte_ready, 1'b0);
        check("rst_epv", ep_value, '0);
        check("rst_epok", ep_ok, '0);

        rst = 1'b0;
        step();
        check("idle_sr", shift_ready, 1'b0);
        check("idle_br", byte_ready, 1'b0);
        check("idle_value", value, 17'h0);

        // Initial load and first shifts
        do_init(8'hA5, 8'h3C);
        check("init_value", value, 17'h0A53C);
        check("init_bits", bits_needed, 4'h8);
        check("init_vv", value_valid, 1'b1);

        shift_valid = 1'b1;
        shift_amt   = 3'd3;
        #1 check("s3_sr", shift_ready, 1'b1);
        check("s3_br", byte_ready, 1'b0);
        step();
        idle_in();
        check("s3_value", value, 17'h129E0);
        check("s3_bits", bits_needed, 4'hB);

        shift_valid = 1'b1;
        shift_amt   = 3'd6;
        byte_valid  = 1'b1;
        byte_data   = 8'hFF;
        #1 check("s6_sr", shift_ready, 1'b1);
        check("s6_br", byte_ready, 1'b1);
        step();
        idle_in();
        check("s6_value", value, 17'h079FE);
        check("s6_bits", bits_needed, 4'h9);

        shift_valid = 1'b1;
        shift_amt   = 3'd0;
        #1 check("s0_sr", shift_ready, 1'b1);
        step();
        idle_in();
        check("s0_value", value, 17'h079FE);
        check("s0_bits", bits_needed, 4'h9);

        shift_valid = 1'b1;
        shift_amt   = 3'd5;
        step();
        idle_in();
        check("s5_value", value, 17'h13FC0);
        check("s5_bits", bits_needed, 4'hE);

        // Lookahead lanes with bits_needed = -2
        byte_valid = 1'b0;
        #1;
`ifdef VALUE_REFILL_LOOKAHEAD_EN
        check("la_ok_nobyte", ep_ok, 4'b0001);
        check("la_lane0", ep_value[0*VW +: VW], 17'h07F80);
`else
        check("la_ok_off", ep_ok, 4'b0000);
        check("la_epv_off", ep_value, '0);
`endif
        check("la_br_nobyte", byte_ready, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'h80;
        #1;
`ifdef VALUE_REFILL_LOOKAHEAD_EN
        check("la_ok_byte", ep_ok, 4'b1111);
        check("la_lane1", ep_value[1*VW +: VW], 17'h0FF80);
        check("la_lane3", ep_value[3*VW +: VW], 17'h1FE00);
`else
        check("la_ok_off_b", ep_ok, 4'b0000);
`endif
        check("la_br_byte", byte_ready, 1'b0);
        step();
        idle_in();

        // start wins over a shift in RUN
        shift_valid = 1'b1;
        shift_amt   = 3'd3;
        start       = 1'b1;
        #1 check("st_sr", shift_ready, 1'b0);
        step();
        start = 1'b0;
        check("st_value", value, 17'h0);
        check("st_bits", bits_needed, 4'h8);
        check("st_vv", value_valid, 1'b0);
        #1 check("st_init_sr", shift_ready, 1'b0);
        check("st_init_br", byte_ready, 1'b1);
        idle_in();
        step();

        // Stall for three cycles, then byte arrives
        do_init(8'hA5, 8'h3C);
        shift_valid = 1'b1;
        shift_amt   = 3'd3;
        step();
        shift_amt  = 3'd6;
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("stall_sr%0d", i), shift_ready, 1'b0);
            check($sformatf("stall_br%0d", i), byte_ready, 1'b0);
            step();
            check($sformatf("stall_val%0d", i), value, 17'h129E0);
            check($sformatf("stall_vv%0d", i), value_valid, 1'b0);
        end
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        #1 check("unstall_sr", shift_ready, 1'b1);
        check("unstall_br", byte_ready, 1'b1);
        step();
        idle_in();
        check("unstall_value", value, 17'h079FE);
        check("unstall_bits", bits_needed, 4'h9);
        check("unstall_vv", value_valid, 1'b1);

        // Reset while stalled
        do_init(8'hA5, 8'h3C);
        shift_valid = 1'b1;
        shift_amt   = 3'd3;
        step();
        shift_amt = 3'd6;
        step();
        check("pre_rst_vv", value_valid, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        rst        = 1'b1;
        #1 check("srst_br", byte_ready, 1'b0);
        check("srst_sr", shift_ready, 1'b0);
        check("srst_value", value, 17'h0);
        check("srst_bits", bits_needed, 4'h8);
        step();
        rst = 1'b0;
        idle_in();
        step();
        check("post_rst_value", value, 17'h0);
        check("post_rst_vv", value_valid, 1'b0);
        check("post_rst_epok", ep_ok, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/value_refill.md
VALUE_REFILL -- requirements
Module: value_refill

Interface
REQ-001 Parameter VALUE_W, default 17: width of the decoder value register (2..32).
REQ-002 Parameter MAX_SHIFT, default 7: largest shift per request (1..8); SHIFT_W = $clog2(MAX_SHIFT+1).
REQ-003 Parameter EP_LANES, default 4: number of bypass lookahead lanes (1..8).
REQ-004 Parameter INIT_BYTES, default 2: bytes loaded at start (1..VALUE_W/8).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle pulse, (re)initialise from the byte stream.
REQ-008 byte_data  in  8  next bitstream byte; byte_valid in 1; byte_ready out 1 (transfer when both high).
REQ-009 shift_valid  in  1; shift_amt in SHIFT_W; shift_ready out 1 (request accepted when both high).
REQ-010 value  out  VALUE_W  registered decoder value; bits_needed out 4 signed, registered.
REQ-011 value_valid  out  1  high only in RUN.
REQ-012 ep_value  out  EP_LANES*VALUE_W  lane k = value after k+1 bypass shifts with byte merge; ep_ok out EP_LANES.

Function
REQ-013 States IDLE, INIT, RUN, STALL; reset to IDLE.
REQ-014 start in any state: go to INIT, clear value to 0, byte counter to 0, bits_needed to -8; start wins over a same-cycle shift (shift_ready=0).
REQ-015 INIT: byte_ready=1; each transfer does value = (value<<8) | byte_data; after INIT_BYTES transfers go to RUN; bits_needed stays -8.
REQ-016 RUN, shift_valid, n = bits_needed + shift_amt < 0: shift_ready=1, value = value<<shift_amt, bits_needed = n, no byte consumed.
REQ-017 RUN, shift_valid, n >= 0, byte_valid=1: shift_ready=1, byte_ready=1, value = (value<<shift_amt) + (byte_data<<n), bits_needed = n-8, same cycle.
REQ-018 RUN, shift_valid, n >= 0, byte_valid=0: shift_ready=0, go to STALL, value/bits_needed unchanged.
REQ-019 STALL: shift_ready=0 until byte_valid; then apply REQ-017 in that cycle, return to RUN; consumer holds shift_valid and shift_amt stable while stalled.
REQ-020 byte_ready SHALL be high only in INIT or in the cycle a byte merge occurs; never in IDLE.
REQ-021 All shifts and adds are modulo 2^VALUE_W; bits shifted out of the MSB are discarded.
REQ-022 shift_amt = 0: accepted in one cycle, no state change; shift_amt > MAX_SHIFT: undefined, flagged by assertion.
REQ-023 bits_needed in RUN SHALL stay within -8..-1.
REQ-024 Shift result visible on value/bits_needed one cycle after acceptance (latency 1).
REQ-025 shift_valid outside RUN/STALL: shift_ready=0, ignored.

Reset
REQ-026 On rst: state IDLE, value=0, bits_needed=-8, value_valid=0, shift_ready=0, byte_ready=0, ep_value=0, ep_ok=0.
REQ-027 rst mid-INIT or mid-STALL SHALL abandon the pending transfer; no byte consumed during reset.

Configuration
REQ-028 Macro VALUE_REFILL_LOOKAHEAD_EN defined: ep_value lane k = (value<<(k+1)) + (bits_needed+k+1 >= 0 ? byte_data<<(bits_needed+k+1) : 0), combinational from registers and byte_data; ep_ok[k] = value_valid & (bits_needed+k+1 < 0 | byte_valid).
REQ-029 Only one byte merge per lane; lanes needing a second byte (bits_needed+k+1 >= 8) SHALL drive ep_ok[k]=0.
REQ-030 Macro undefined: ports kept, ep_value and ep_ok tied to 0, no lookahead logic.

Verification
REQ-031 start, bytes 0xA5,0x3C -> after 2 transfers RUN, value=0x0A53C, bits_needed=-8, value_valid=1.
REQ-032 From REQ-031, shift_amt=3 -> value=0x129E0, bits_needed=-5, no byte consumed.
REQ-033 Then shift_amt=6 with byte 0xFF valid -> same-cycle accept, value=0x079FE, bits_needed=-7, byte_ready=1.
REQ-034 Same as REQ-033 with byte_valid low 3 cycles -> STALL, shift_ready=0 for 3 cycles, value held 0x129E0, then 0x079FE on arrival.
REQ-035 LOOKAHEAD_EN, bits_needed=-2, byte_valid=0 -> ep_ok=4'b0001; byte 0x80 valid -> ep_ok=4'b1111, lane1 = (value<<2)+0x80.
REQ-036 rst asserted in STALL, and start together with shift_valid in RUN -> REQ-026 values; start path: INIT entered, shift_ready=0.
